// File: rtl/uart_rx_line.sv
// 8-bit UART receiver (LSB first, idle-high) with a 2-flop line synchronizer and one-cycle result strobes.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx_line #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_valid_nxt;
    logic          w_frame_err_nxt;
    logic          w_fall;
    logic          w_tick_half;
    logic          w_tick_full;
    logic          w_par_bad;

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;
    logic w_par_nxt;
    assign w_par_bad  = ^{r_shift, r_par};
    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign w_fall      = r_prev & ~r_sync2;
    assign w_tick_half = (r_cnt == HALF_M1);
    assign w_tick_full = (r_cnt == FULL_M1);

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;

    // Synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par        <= w_par_nxt;
            r_parity_err <= (r_state == S_STOP) && w_tick_full && w_par_bad;
        end
    end
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + CW'(1);
        w_bit_nxt       = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt       = r_par;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A line back high at mid-start is treated as a glitch.
                if (w_tick_half) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick_full) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick_full) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = r_sync2;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
                if (w_tick_full) begin
                    w_cnt_nxt       = '0;
                    w_data_nxt      = r_shift;
                    w_frame_err_nxt = ~r_sync2;
                    w_valid_nxt     = r_sync2 & ~w_par_bad;
                    w_state_nxt     = r_sync2 ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (r_sync2) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_line.sv
// Directed bench for uart_rx_line at CLKS_PER_BIT=8 with an ideal bit-aligned transmitter.
`timescale 1ns/1ps
module tb_uart_rx_line;

    localparam int CPB = 8;
    // Frame start drive (cycle t0) to strobe-visible cycle: 3 sync/detect + 4 half bit + 9 or 10 bits.
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 87;
`else
    localparam int LAT = 79;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int fe_cyc   = -1;
    int pe_cnt   = 0;
    int v_data[$];
    int v_cyc[$];

    uart_rx_line #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            v_data.push_back(int'(data));
            v_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (parity_err === 1'b1) pe_cnt = pe_cnt + 1;
    end

    function automatic int vd(input int i);
        return (i < v_data.size()) ? v_data[i] : -1;
    endfunction

    function automatic int vc(input int i);
        return (i < v_cyc.size()) ? v_cyc[i] : -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        v_data.delete();
        v_cyc.delete();
        fe_cnt = 0;
        fe_cyc = -1;
    endtask

    // Called at #1 after an edge; returns at #1 after the edge ending the stop bit, line left at stop level.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, output int t0);
        rx = 1'b0;
        t0 = cyc;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_cyc(CPB);
`else
        if (par !== 1'b0 && par !== 1'b1) rx = 1'b1;
`endif
        rx = stop;
        wait_cyc(CPB);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        wait_cyc(3);
        chk_cnt++; if (data !== 8'h00) $display("FAIL reset_data got %h want 00", data); else pass_cnt++;
        chk_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else pass_cnt++;
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else pass_cnt++;
        chk_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err got %b want 0", parity_err); else pass_cnt++;
        rst = 1'b0;
        clear_log();
        pe_cnt = 0;
        wait_cyc(200);
        chk_cnt++; if (v_data.size() != 0) $display("FAIL idle_valid got %0d pulses want 0", v_data.size()); else pass_cnt++;
        chk_cnt++; if (fe_cnt != 0) $display("FAIL idle_frame_err got %0d pulses want 0", fe_cnt); else pass_cnt++;
        chk_cnt++; if (pe_cnt != 0) $display("FAIL idle_parity_err got %0d pulses want 0", pe_cnt); else pass_cnt++;
    endtask

    task automatic test_single();
        int t0;
        clear_log();
        send_frame(8'hA5, 1'b0, 1'b1, t0);
        wait_cyc(4);
        chk_cnt++; if (v_data.size() != 1) $display("FAIL single_count got %0d want 1", v_data.size()); else pass_cnt++;
        chk_cnt++; if (vd(0) != 'hA5) $display("FAIL single_data got %h want a5", vd(0)); else pass_cnt++;
        chk_cnt++; if (vc(0) != t0 + LAT) $display("FAIL single_timing got %0d want %0d", vc(0), t0 + LAT); else pass_cnt++;
        chk_cnt++; if (fe_cnt != 0) $display("FAIL single_frame_err got %0d want 0", fe_cnt); else pass_cnt++;
        chk_cnt++; if (data !== 8'hA5) $display("FAIL single_data_hold got %h want a5", data); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ta, tb;
        clear_log();
        send_frame(8'h00, 1'b0, 1'b1, ta);
        send_frame(8'hFF, 1'b0, 1'b1, tb);
        wait_cyc(4);
        chk_cnt++; if (v_data.size() != 2) $display("FAIL b2b_count got %0d want 2", v_data.size()); else pass_cnt++;
        chk_cnt++; if (vd(0) != 'h00) $display("FAIL b2b_data0 got %h want 00", vd(0)); else pass_cnt++;
        chk_cnt++; if (vd(1) != 'hFF) $display("FAIL b2b_data1 got %h want ff", vd(1)); else pass_cnt++;
        chk_cnt++; if (vc(0) != ta + LAT) $display("FAIL b2b_timing0 got %0d want %0d", vc(0), ta + LAT); else pass_cnt++;
        chk_cnt++; if (vc(1) - vc(0) != 10 * CPB + (LAT - 79)) $display("FAIL b2b_spacing got %0d want %0d", vc(1) - vc(0), 10 * CPB + (LAT - 79)); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int t0;
        clear_log();
        rx = 1'b0;
        wait_cyc(2);
        rx = 1'b1;
        wait_cyc(20);
        chk_cnt++; if (v_data.size() != 0 || fe_cnt != 0) $display("FAIL glitch_strobe got valid=%0d ferr=%0d want 0/0", v_data.size(), fe_cnt); else pass_cnt++;
        send_frame(8'h3C, 1'b0, 1'b1, t0);
        wait_cyc(4);
        chk_cnt++; if (vd(0) != 'h3C || v_data.size() != 1) $display("FAIL glitch_next got %h x%0d want 3c x1", vd(0), v_data.size()); else pass_cnt++;
        chk_cnt++; if (vc(0) != t0 + LAT) $display("FAIL glitch_next_timing got %0d want %0d", vc(0), t0 + LAT); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int t0;
        clear_log();
        send_frame(8'h81, 1'b0, 1'b0, t0);
        wait_cyc(50);
        rx = 1'b1;
        wait_cyc(20);
        chk_cnt++; if (fe_cnt != 1) $display("FAIL ferr_count got %0d want 1", fe_cnt); else pass_cnt++;
        chk_cnt++; if (fe_cyc != t0 + LAT) $display("FAIL ferr_timing got %0d want %0d", fe_cyc, t0 + LAT); else pass_cnt++;
        chk_cnt++; if (v_data.size() != 0) $display("FAIL ferr_valid got %0d want 0", v_data.size()); else pass_cnt++;
        chk_cnt++; if (data !== 8'h81) $display("FAIL ferr_data got %h want 81", data); else pass_cnt++;
        send_frame(8'h42, 1'b0, 1'b1, t0);
        wait_cyc(4);
        chk_cnt++; if (vd(0) != 'h42 || v_data.size() != 1) $display("FAIL ferr_next got %h x%0d want 42 x1", vd(0), v_data.size()); else pass_cnt++;
        chk_cnt++; if (fe_cnt != 1) $display("FAIL ferr_next_ferr got %0d want 1", fe_cnt); else pass_cnt++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int t0;
        clear_log();
        pe_cnt = 0;
        send_frame(8'h07, 1'b1, 1'b1, t0);
        wait_cyc(4);
        chk_cnt++; if (vd(0) != 'h07 || v_data.size() != 1) $display("FAIL par_good got %h x%0d want 07 x1", vd(0), v_data.size()); else pass_cnt++;
        chk_cnt++; if (pe_cnt != 0) $display("FAIL par_good_perr got %0d want 0", pe_cnt); else pass_cnt++;
        send_frame(8'h07, 1'b0, 1'b1, t0);
        wait_cyc(4);
        chk_cnt++; if (pe_cnt != 1) $display("FAIL par_bad_perr got %0d want 1", pe_cnt); else pass_cnt++;
        chk_cnt++; if (v_data.size() != 1) $display("FAIL par_bad_valid got %0d want 1", v_data.size()); else pass_cnt++;
        chk_cnt++; if (data !== 8'h07) $display("FAIL par_bad_data got %h want 07", data); else pass_cnt++;
    endtask
`else
    task automatic test_parity();
        chk_cnt++; if (pe_cnt != 0) $display("FAIL par_tied got %0d pulses want 0", pe_cnt); else pass_cnt++;
    endtask
`endif

    task automatic test_reset_midframe();
        logic [7:0] b;
        int t0;
        b = 8'h5A;
        clear_log();
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rst = 1'b1;
        wait_cyc(3);
        rx = 1'b1;
        chk_cnt++; if (data !== 8'h00) $display("FAIL mid_rst_data got %h want 00", data); else pass_cnt++;
        rst = 1'b0;
        wait_cyc(20 * CPB);
        chk_cnt++; if (v_data.size() != 0 || fe_cnt != 0) $display("FAIL mid_rst_strobe got valid=%0d ferr=%0d want 0/0", v_data.size(), fe_cnt); else pass_cnt++;
        chk_cnt++; if (data !== 8'h00) $display("FAIL mid_rst_data_after got %h want 00", data); else pass_cnt++;
        send_frame(8'h5A, 1'b0, 1'b1, t0);
        wait_cyc(4);
        chk_cnt++; if (vd(0) != 'h5A || v_data.size() != 1) $display("FAIL mid_rst_next got %h x%0d want 5a x1", vd(0), v_data.size()); else pass_cnt++;
        chk_cnt++; if (vc(0) != t0 + LAT) $display("FAIL mid_rst_timing got %0d want %0d", vc(0), t0 + LAT); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_parity();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
